// File: rtl/add_rr_scheduler.sv
// Round-robin scheduler sharing one adder among NUM_REQ requesters, with a
// one-deep registered result stage and a saturating overflow counter.

module add #(
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 8
) (
  input  logic [IN_SIZE-1:0]  a,
  input  logic [IN_SIZE-1:0]  b,
  output logic [OUT_SIZE-1:0] sum,
  output logic                overflow
);
  // Wide enough for the true sum or the OUT_SIZE+1 result, whichever is larger.
  localparam int W = (IN_SIZE > OUT_SIZE) ? IN_SIZE + 1 : OUT_SIZE + 1;

  logic [W-1:0] full_s;

  assign full_s   = W'(a) + W'(b);
  assign sum      = full_s[OUT_SIZE-1:0];
  assign overflow = full_s[OUT_SIZE];
endmodule

module add_rr_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int IN_SIZE  = 8,
  parameter int OUT_SIZE = 8,
  parameter int CNT_W    = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*IN_SIZE-1:0] req_a,
  input  logic [NUM_REQ*IN_SIZE-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [OUT_SIZE-1:0]        rsp_sum,
  output logic                       rsp_overflow,
  output logic [ID_W-1:0]            rsp_id,
  output logic [CNT_W-1:0]           ovf_count
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [OUT_SIZE-1:0] sum_q, sum_d;
  logic                ovf_q, ovf_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                found_s;
  logic                can_accept_s;
  logic                transfer_s;
  logic [IN_SIZE-1:0]  a_sel_s, b_sel_s;
  logic [OUT_SIZE-1:0] add_sum_s;
  logic                add_ovf_s;

  // Rotating priority search starting at ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        found_s      = 1'b1;
        grant_idx_s  = ID_W'(idx);
        grant_s[idx] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign can_accept_s = !rsp_valid | rsp_ready;
  assign req_ready    = grant_s & {NUM_REQ{can_accept_s & rst_n}};
  assign transfer_s   = found_s & can_accept_s & rst_n;

  assign a_sel_s = req_a[grant_idx_s*IN_SIZE +: IN_SIZE];
  assign b_sel_s = req_b[grant_idx_s*IN_SIZE +: IN_SIZE];

  add #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE)
  ) u_add (
    .a        (a_sel_s),
    .b        (b_sel_s),
    .sum      (add_sum_s),
    .overflow (add_ovf_s)
  );

  // Output-stage FSM, pointer update and overflow counting.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY: begin
        if (transfer_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (transfer_s) begin
          state_d = FULL;
        end else if (rsp_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (transfer_s) begin
      sum_d = add_sum_s;
      ovf_d = add_ovf_s;
      id_d  = grant_idx_s;
      if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + ID_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end

    // Saturate rather than wrap so a large count is never mistaken for a small one.
    if (transfer_s && add_ovf_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid    = (state_q == FULL);
  assign rsp_sum      = sum_q;
  assign rsp_overflow = ovf_q;
  assign rsp_id       = id_q;
  assign ovf_count    = cnt_q;
endmodule
